model_write_weighting: RTL and testbench

- Computes the DNC write weighting element by element: w(t;j) = gw·(ga·a(t;j) + (1−ga)·c(t;j)), for j in 0 to N-1.
  - a is the allocation weighting.
  - c is the write content weighting.
  - ga is the allocation gate; gw is the write gate.
- It is the write-side counterpart of the read weighting block in the DNC memory path.
- It streams a and c in over request/enable handshakes and streams w out. Arithmetic is unsigned fixed point.

---
 rtl/model_write_weighting_if.sv | 31 +++
 rtl/model_write_weighting.sv | 222 ++++++++++++++++++++++
 tb/tb_model_write_weighting.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/model_write_weighting_if.sv
// Handshake and data bundle between the write-weighting block and its
// producer/consumer: operand requests, operand delivery and result stream.
interface model_write_weighting_if #(
   parameter int DATA_SIZE = 64
);
   logic                 start;
   logic                 ready;
   logic                 a_in_enable;
   logic                 c_in_enable;
   logic                 a_out_enable;
   logic                 c_out_enable;
   logic                 w_out_enable;
   logic [DATA_SIZE-1:0] size_n_in;
   logic [DATA_SIZE-1:0] ga_in;
   logic [DATA_SIZE-1:0] gw_in;
   logic [DATA_SIZE-1:0] a_in;
   logic [DATA_SIZE-1:0] c_in;
   logic [DATA_SIZE-1:0] w_out;

   modport slave (
      input  start, size_n_in, ga_in, gw_in,
      input  a_in_enable, c_in_enable, a_in, c_in,
      output ready, a_out_enable, c_out_enable, w_out_enable, w_out
   );

   modport master (
      output start, size_n_in, ga_in, gw_in,
      output a_in_enable, c_in_enable, a_in, c_in,
      input  ready, a_out_enable, c_out_enable, w_out_enable, w_out
   );
endinterface

// File: rtl/model_write_weighting.sv
// DNC write weighting w(j) = gw*(ga*a(j) + (1-ga)*c(j)) in unsigned fixed point,
// one element per pass through WAIT -> MUL -> ADD -> OUT.
module model_write_weighting #(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 64,
   parameter int FRACTION     = 32
) (
   input logic                    clk_i,
   input logic                    rst_ni,
   model_write_weighting_if.slave bus
);
   localparam logic [DATA_SIZE-1:0]    ONE     = {{(DATA_SIZE-1){1'b0}}, 1'b1} << FRACTION;
   localparam logic [DATA_SIZE-1:0]    SAT_MAX = {DATA_SIZE{1'b1}};
   localparam logic [DATA_SIZE-1:0]    D_ZERO  = {DATA_SIZE{1'b0}};
   localparam logic [CONTROL_SIZE-1:0] IDX_ONE = {{(CONTROL_SIZE-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_MUL  = 3'd2,
      S_ADD  = 3'd3,
      S_OUT  = 3'd4
   } state_t;

   function automatic logic [DATA_SIZE-1:0] clamp_gate(input logic [DATA_SIZE-1:0] g);
      logic [DATA_SIZE-1:0] r;
      if (g > ONE) begin
         r = ONE;
      end else begin
         r = g;
      end
      return r;
   endfunction

   // Full double-width product, rescaled by the fraction and truncated.
   function automatic logic [DATA_SIZE-1:0] fx_mul(input logic [DATA_SIZE-1:0] x,
                                                  input logic [DATA_SIZE-1:0] y);
      return DATA_SIZE'(({{DATA_SIZE{1'b0}}, x} * {{DATA_SIZE{1'b0}}, y}) >> FRACTION);
   endfunction

   function automatic logic [DATA_SIZE-1:0] sat_add(input logic [DATA_SIZE-1:0] x,
                                                   input logic [DATA_SIZE-1:0] y);
      logic [DATA_SIZE:0] sum;
      logic [DATA_SIZE-1:0] r;
      sum = {1'b0, x} + {1'b0, y};
      if (sum[DATA_SIZE]) begin
         r = SAT_MAX;
      end else begin
         r = sum[DATA_SIZE-1:0];
      end
      return r;
   endfunction

   state_t                  state_q, state_d;
   logic [CONTROL_SIZE-1:0] index_q, index_d;
   logic [DATA_SIZE-1:0]    n_q, n_d;
   logic [DATA_SIZE-1:0]    ga_q, ga_d;
   logic [DATA_SIZE-1:0]    gw_q, gw_d;
   logic [DATA_SIZE-1:0]    a_q, a_d;
   logic [DATA_SIZE-1:0]    c_q, c_d;
   logic                    a_got_q, a_got_d;
   logic                    c_got_q, c_got_d;
   logic [DATA_SIZE-1:0]    p1_q, p1_d;
   logic [DATA_SIZE-1:0]    p2_q, p2_d;
   logic [DATA_SIZE-1:0]    s_q, s_d;
   logic [DATA_SIZE-1:0]    w_out_q, w_out_d;
   logic                    ready_q, ready_d;
   logic                    a_req_q, a_req_d;
   logic                    c_req_q, c_req_d;
   logic                    w_en_q, w_en_d;
   logic [CONTROL_SIZE-1:0] last_idx_s;

   assign last_idx_s = CONTROL_SIZE'(n_q) - IDX_ONE;

   // Next-state and pulse generation; every pulse defaults low each cycle.
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      n_d     = n_q;
      ga_d    = ga_q;
      gw_d    = gw_q;
      a_d     = a_q;
      c_d     = c_q;
      a_got_d = a_got_q;
      c_got_d = c_got_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      s_d     = s_q;
      w_out_d = w_out_q;
      ready_d = 1'b0;
      a_req_d = 1'b0;
      c_req_d = 1'b0;
      w_en_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               n_d     = bus.size_n_in;
               ga_d    = clamp_gate(bus.ga_in);
               gw_d    = clamp_gate(bus.gw_in);
               index_d = {CONTROL_SIZE{1'b0}};
               a_got_d = 1'b0;
               c_got_d = 1'b0;
               if (bus.size_n_in == D_ZERO) begin
                  ready_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  a_req_d = 1'b1;
                  c_req_d = 1'b1;
                  state_d = S_WAIT;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_WAIT: begin
            // Only the first enable per operand is taken; repeats are dropped.
            if (bus.a_in_enable && !a_got_q) begin
               a_d     = bus.a_in;
               a_got_d = 1'b1;
            end else begin
               a_d     = a_q;
               a_got_d = a_got_q;
            end
            if (bus.c_in_enable && !c_got_q) begin
               c_d     = bus.c_in;
               c_got_d = 1'b1;
            end else begin
               c_d     = c_q;
               c_got_d = c_got_q;
            end
            if (a_got_d && c_got_d) begin
               state_d = S_MUL;
            end else begin
               state_d = S_WAIT;
            end
         end

         S_MUL: begin
            p1_d    = fx_mul(ga_q, a_q);
            p2_d    = fx_mul(ONE - ga_q, c_q);
            state_d = S_ADD;
         end

         S_ADD: begin
            s_d     = sat_add(p1_q, p2_q);
            state_d = S_OUT;
         end

         S_OUT: begin
            w_out_d = fx_mul(gw_q, s_q);
            w_en_d  = 1'b1;
            a_got_d = 1'b0;
            c_got_d = 1'b0;
            if (index_q == last_idx_s) begin
               ready_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               index_d = index_q + IDX_ONE;
               a_req_d = 1'b1;
               c_req_d = 1'b1;
               state_d = S_WAIT;
            end
         end

         default: begin
            state_d = S_IDLE;
            a_got_d = 1'b0;
            c_got_d = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         index_q <= {CONTROL_SIZE{1'b0}};
         n_q     <= D_ZERO;
         ga_q    <= D_ZERO;
         gw_q    <= D_ZERO;
         a_q     <= D_ZERO;
         c_q     <= D_ZERO;
         a_got_q <= 1'b0;
         c_got_q <= 1'b0;
         p1_q    <= D_ZERO;
         p2_q    <= D_ZERO;
         s_q     <= D_ZERO;
         w_out_q <= D_ZERO;
         ready_q <= 1'b0;
         a_req_q <= 1'b0;
         c_req_q <= 1'b0;
         w_en_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         n_q     <= n_d;
         ga_q    <= ga_d;
         gw_q    <= gw_d;
         a_q     <= a_d;
         c_q     <= c_d;
         a_got_q <= a_got_d;
         c_got_q <= c_got_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         s_q     <= s_d;
         w_out_q <= w_out_d;
         ready_q <= ready_d;
         a_req_q <= a_req_d;
         c_req_q <= c_req_d;
         w_en_q  <= w_en_d;
      end
   end

   assign bus.ready        = ready_q;
   assign bus.a_out_enable = a_req_q;
   assign bus.c_out_enable = c_req_q;
   assign bus.w_out_enable = w_en_q;
   assign bus.w_out        = w_out_q;

endmodule

// File: tb/tb_model_write_weighting.sv
// Randomized and directed bench for model_write_weighting: a cycle-level
// expectation queue built from the latency rules, checked every cycle.
module tb_model_write_weighting;
   localparam int          DS  = 64;
   localparam logic [63:0] ONE = 64'h0000_0001_0000_0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   model_write_weighting_if #(.DATA_SIZE(DS)) bus();

   model_write_weighting #(
      .DATA_SIZE(DS),
      .CONTROL_SIZE(64),
      .FRACTION(32)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int          at;
      bit          w;
      bit          rdy;
      bit          req;
      logic [63:0] val;
   } ev_t;

   ev_t         evq[$];
   logic [63:0] a_v[8];
   logic [63:0] c_v[8];
   int          da_v[8];
   int          dc_v[8];
   bit          dup_en;
   logic [63:0] last_w;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [63:0] clamp1(input logic [63:0] g);
      return (g > ONE) ? ONE : g;
   endfunction

   function automatic logic [63:0] fxm(input logic [63:0] x, input logic [63:0] y);
      logic [127:0] p;
      p = ({64'd0, x} * {64'd0, y}) >> 32;
      return p[63:0];
   endfunction

   function automatic logic [63:0] model_w(input logic [63:0] ga, input logic [63:0] gw,
                                           input logic [63:0] a, input logic [63:0] c);
      logic [63:0] g;
      logic [64:0] s;
      logic [63:0] ss;
      g  = clamp1(ga);
      s  = {1'b0, fxm(g, a)} + {1'b0, fxm(ONE - g, c)};
      ss = s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
      return fxm(clamp1(gw), ss);
   endfunction

   // Per-cycle comparison against the expectation queue.
   initial begin
      bit          ew;
      bit          er;
      bit          eq;
      logic [63:0] ev_val;
      ev_t         e;
      last_w = 64'd0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            last_w = 64'd0;
         end else begin
            ew = 1'b0; er = 1'b0; eq = 1'b0; ev_val = 64'd0;
            if (evq.size() > 0 && evq[0].at == cyc) begin
               e = evq.pop_front();
               ew = e.w; er = e.rdy; eq = e.req; ev_val = e.val;
            end
            if (ew) last_w = ev_val;
            chk("w_out_enable", 64'(bus.w_out_enable), 64'(ew));
            chk("ready",        64'(bus.ready),        64'(er));
            chk("a_out_enable", 64'(bus.a_out_enable), 64'(eq));
            chk("c_out_enable", 64'(bus.c_out_enable), 64'(eq));
            chk("w_out",        bus.w_out,             last_w);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_ready"}, 64'(bus.ready),        64'd0);
      chk({tag, "_aoe"},   64'(bus.a_out_enable), 64'd0);
      chk({tag, "_coe"},   64'(bus.c_out_enable), 64'd0);
      chk({tag, "_woe"},   64'(bus.w_out_enable), 64'd0);
      chk({tag, "_wout"},  bus.w_out,             64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("midreset");
      evq.delete();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (4) tick();
   endtask

   task automatic run_vec(input int n, input logic [63:0] ga, input logic [63:0] gw,
                          input int stop_at);
      int s;
      int e;
      int mx;
      bus.start     = 1'b1;
      bus.size_n_in = 64'(n);
      bus.ga_in     = ga;
      bus.gw_in     = gw;
      tick();
      bus.start     = 1'b0;
      bus.ga_in     = {$urandom(), $urandom()};
      bus.gw_in     = {$urandom(), $urandom()};
      bus.size_n_in = 64'($urandom_range(9));
      s = cyc;
      if (n == 0) begin
         evq.push_back('{at: s, w: 1'b0, rdy: 1'b1, req: 1'b0, val: 64'd0});
         return;
      end
      evq.push_back('{at: s, w: 1'b0, rdy: 1'b0, req: 1'b1, val: 64'd0});
      for (int j = 0; j < n; j++) begin
         if (j == stop_at) begin
            do_reset();
            return;
         end
         mx = (da_v[j] > dc_v[j]) ? da_v[j] : dc_v[j];
         for (int t = 0; t <= mx; t++) begin
            bus.a_in_enable = (t == da_v[j]) || (dup_en && t > da_v[j]);
            bus.a_in        = (t == da_v[j]) ? a_v[j] : {$urandom(), $urandom()};
            bus.c_in_enable = (t == dc_v[j]) || (dup_en && t > dc_v[j]);
            bus.c_in        = (t == dc_v[j]) ? c_v[j] : {$urandom(), $urandom()};
            bus.start       = 1'($urandom_range(1));
            tick();
         end
         e = cyc;
         evq.push_back('{at: e + 3, w: 1'b1, rdy: (j == n - 1), req: (j != n - 1),
                         val: model_w(ga, gw, a_v[j], c_v[j])});
         // Enables and START during MUL/ADD/OUT must have no effect.
         for (int k = 0; k < 3; k++) begin
            bus.a_in_enable = 1'($urandom_range(1));
            bus.c_in_enable = 1'($urandom_range(1));
            bus.a_in        = {$urandom(), $urandom()};
            bus.c_in        = {$urandom(), $urandom()};
            bus.start       = 1'($urandom_range(1));
            tick();
         end
         bus.a_in_enable = 1'b0;
         bus.c_in_enable = 1'b0;
         bus.start       = 1'b0;
      end
   endtask

   task automatic set_delays(input int da, input int dc);
      for (int j = 0; j < 8; j++) begin
         da_v[j] = da;
         dc_v[j] = dc;
      end
   endtask

   initial begin
      logic [63:0] g;
      int          n;
      bus.start = 1'b0; bus.size_n_in = 64'd0; bus.ga_in = 64'd0; bus.gw_in = 64'd0;
      bus.a_in_enable = 1'b0; bus.c_in_enable = 1'b0; bus.a_in = 64'd0; bus.c_in = 64'd0;
      dup_en = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_zero_outputs("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // Pass-through of a with unity gates.
      a_v[0] = 64'h4000_0000; a_v[1] = 64'h8000_0000;
      c_v[0] = 64'hFFFF;      c_v[1] = 64'h1234;
      chk("pin_a0", model_w(ONE, ONE, a_v[0], c_v[0]), 64'h4000_0000);
      chk("pin_a1", model_w(ONE, ONE, a_v[1], c_v[1]), 64'h8000_0000);
      set_delays(0, 0);
      run_vec(2, ONE, ONE, -1);

      // Pass-through of c with ga = 0.
      a_v[0] = 64'hDEAD; a_v[1] = 64'hBEEF; a_v[2] = 64'h55;
      c_v[0] = 64'd1; c_v[1] = 64'h1_0000_0000; c_v[2] = 64'd7;
      chk("pin_c1", model_w(64'd0, ONE, a_v[1], c_v[1]), 64'h1_0000_0000);
      chk("pin_c2", model_w(64'd0, ONE, a_v[2], c_v[2]), 64'd7);
      set_delays(1, 0);
      run_vec(3, 64'd0, ONE, -1);

      // Half gates, then an over-range allocation gate.
      a_v[0] = 64'h1_0000_0000; c_v[0] = 64'd0;
      chk("pin_half", model_w(64'h8000_0000, 64'h8000_0000, a_v[0], c_v[0]), 64'h4000_0000);
      set_delays(0, 1);
      run_vec(1, 64'h8000_0000, 64'h8000_0000, -1);
      a_v[0] = 64'd5; c_v[0] = 64'd9;
      chk("pin_clamp", model_w(64'h3_0000_0000, ONE, a_v[0], c_v[0]), 64'd5);
      run_vec(1, 64'h3_0000_0000, ONE, -1);

      // a two cycles ahead of c with a duplicate, then both together.
      a_v[0] = 64'h1111_2222; c_v[0] = 64'h3333;
      a_v[1] = 64'h7777;      c_v[1] = 64'h9999_0000;
      da_v[0] = 0; dc_v[0] = 2; da_v[1] = 0; dc_v[1] = 0;
      dup_en = 1'b1;
      run_vec(2, 64'h4000_0000, 64'hC000_0000, -1);
      dup_en = 1'b0;

      // Empty vector.
      run_vec(0, ONE, ONE, -1);
      repeat (2) tick();

      // Reset between the first and second of four elements.
      for (int j = 0; j < 4; j++) begin
         a_v[j] = {$urandom(), $urandom()};
         c_v[j] = {$urandom(), $urandom()};
      end
      set_delays(0, 0);
      run_vec(4, 64'h2000_0000, ONE, 1);
      a_v[0] = 64'h1234_5678; c_v[0] = 64'h8765_4321;
      run_vec(1, 64'h6000_0000, 64'hE000_0000, -1);

      // Random vectors.
      for (int v = 0; v < 12; v++) begin
         n = $urandom_range(1, 5);
         for (int j = 0; j < n; j++) begin
            a_v[j]  = ($urandom_range(1) == 1) ? {$urandom(), $urandom()} : {31'd0, 1'($urandom_range(1)), $urandom()};
            c_v[j]  = ($urandom_range(1) == 1) ? {$urandom(), $urandom()} : {31'd0, 1'($urandom_range(1)), $urandom()};
            da_v[j] = $urandom_range(3);
            dc_v[j] = $urandom_range(3);
         end
         dup_en = 1'($urandom_range(1));
         case ($urandom_range(3))
            0: g = ONE;
            1: g = 64'd0;
            2: g = {32'd0, $urandom()};
            default: g = {29'd0, 3'($urandom_range(7)), $urandom()};
         endcase
         run_vec(n, g, {31'd0, 1'($urandom_range(1)), $urandom()}, -1);
         repeat ($urandom_range(2)) tick();
      end

      repeat (4) tick();
      chk("events_drained", 64'(evq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
